// File: rtl/softmax_pkg.sv
// Shared constants, FSM state encoding and lane array types for the softmax
// sequencer and its output serializer.
package softmax_pkg;

  localparam int N_LANES = 5;
  localparam int DW_IN   = 16;
  localparam int DW_OUT  = 17;

  // Element / lane counters must be able to hold the value N_LANES itself.
  localparam int CW = $clog2(N_LANES + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_LAST = cnt_t'(N_LANES - 1);

  typedef enum logic [1:0] {
    LOAD,
    DISCARD,
    RUN,
    DRAIN
  } state_t;

  // Index 0 of each array is lane 1 (the first element of the vector).
  typedef logic [N_LANES-1:0][DW_IN-1:0]  lane_in_t;
  typedef logic [N_LANES-1:0][DW_OUT-1:0] lane_out_t;

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Input and output valid/ready streams of the softmax sequencer.
// master = stream source/sink side, slave = sequencer side.
interface softmax_seq_ctrl_if;
  import softmax_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DW_IN-1:0]  in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DW_OUT-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/softmax_out_ser.sv
// Output serializer: captures the core results once per vector and streams
// lanes 1..nvec out on a valid/ready port, holding data under backpressure.
module softmax_out_ser
  import softmax_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  lane_out_t         core_y,
  input  cnt_t              nvec,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DW_OUT-1:0] out_data,
  output logic              out_last
);

  lane_out_t obuf;
  cnt_t      idx;

  // Result buffer: written once per vector when the core window closes.
  // NOTE: obuf carries no reset; out_valid is the only qualifier, so clearing the data buffer buys nothing.
  always_ff @(posedge clk) begin
    if (capture) obuf <= core_y;
  end

  // Beat sequencing: lane 1 is presented straight from core_y at capture,
  // later lanes come from obuf; nothing moves while the sink stalls.
  // NOTE: all state here uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      idx       <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= core_y[0];
      out_last  <= (nvec == CNT_ONE);
      idx       <= CNT_ONE;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        idx       <= '0;
      end else begin
        // idx is the 1-based lane just sent, so obuf[idx] is the next lane.
        out_data  <= obuf[idx];
        out_last  <= ((idx + CNT_ONE) == nvec);
        idx       <= idx + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer for the combinational 5-lane softmax core: gathers one vector
// from the input stream, pads unused lanes, holds core_x for CORE_LAT cycles,
// captures core_y and streams the results back out.
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int               CORE_LAT = 4,        // 1..15
  parameter logic [DW_IN-1:0] PAD_VAL  = 16'h8000
) (
  input  logic                     clk,
  input  logic                     rst,
  softmax_seq_ctrl_if.slave        bus,
  output lane_in_t                 core_x,
  input  lane_out_t                core_y,
  output logic                     busy,
  output logic                     err_len,
  output logic [15:0]              vec_count
);

  localparam logic [3:0] LAT_INIT = 4'(CORE_LAT - 1);

  state_t     state;
  cnt_t       cnt;
  cnt_t       nvec;
  logic [3:0] lat_cnt;
  logic       in_fire;
  logic       out_done;
  logic       capture;

  // The reset term keeps in_ready low during the cycle reset is applied.
  assign bus.in_ready = ((state == LOAD) || (state == DISCARD)) && !rst;
  assign busy         = (state != LOAD);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_done     = bus.out_valid && bus.out_ready && bus.out_last;
  assign capture      = (state == RUN) && (lat_cnt == 4'd0);

  // Control FSM: collect, optionally discard overflow, wait out the core, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      nvec      <= '0;
      lat_cnt   <= '0;
      err_len   <= 1'b0;
      vec_count <= '0;
      core_x    <= {N_LANES{PAD_VAL}};
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            core_x[cnt] <= bus.in_data;
            cnt         <= cnt + CNT_ONE;
            if (bus.in_last || (cnt == CNT_LAST)) begin
              // Lanes above the one just written belong to no element.
              for (int i = 0; i < N_LANES; i++) begin
                if (i > int'(cnt)) core_x[i] <= PAD_VAL;
              end
              nvec    <= cnt + CNT_ONE;
              lat_cnt <= LAT_INIT;
              if (bus.in_last) begin
                state <= RUN;
              end else begin
                state   <= DISCARD;
                err_len <= 1'b1;
              end
            end
          end
        end
        DISCARD: begin
          if (in_fire && bus.in_last) begin
            lat_cnt <= LAT_INIT;
            state   <= RUN;
          end
        end
        RUN: begin
          if (lat_cnt == 4'd0) state <= DRAIN;
          else                 lat_cnt <= lat_cnt - 4'd1;
        end
        DRAIN: begin
          if (out_done) begin
            vec_count <= vec_count + 16'd1;
            cnt       <= '0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  softmax_out_ser u_out_ser (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .core_y    (core_y),
    .nvec      (nvec),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last)
  );

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl with a y = x + 1 core stub. A vector-level model
// predicts beats, vec_count, err_len, padding and latency; directed tests pin
// literal results.
module tb_softmax_seq_ctrl;
  import softmax_pkg::*;

  localparam int         LAT = 4;
  localparam logic [15:0] PAD = 16'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  lane_in_t    core_x;
  lane_out_t   core_y;
  logic        busy;
  logic        err_len;
  logic [15:0] vec_count;

  softmax_seq_ctrl_if bus ();

  softmax_seq_ctrl #(.CORE_LAT(LAT), .PAD_VAL(PAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_x    (core_x),
    .core_y    (core_y),
    .busy      (busy),
    .err_len   (err_len),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  // Core stub: each lane result is its input zero-extended plus one.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) core_y[i] = {1'b0, core_x[i]} + 17'd1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name,
                       input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model state ----------------
  logic [15:0] cur[$];
  logic [16:0] exp_d[$];
  bit          exp_l[$];
  int          got_q[$];
  int          acc_n = 0;
  logic [15:0] model_vc = 16'd0;
  bit          err_m = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          lat_pending = 1'b0;
  int          first_lat = -1;
  bit          just_last = 1'b0;
  lane_in_t    exp_x;
  bit          prev_stall = 1'b0;
  logic [18:0] hold_v;

  // Compare process: samples on the falling edge, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cur.delete(); exp_d.delete(); exp_l.delete();
      acc_n = 0; model_vc = 16'd0; err_m = 1'b0;
      lat_pending = 1'b0; just_last = 1'b0; prev_stall = 1'b0;
    end else begin
      cyc++;
      check(vec_count == model_vc, "vec_count", vec_count, model_vc);
      check(err_len == err_m, "err_len", err_len, err_m);
      if (bus.out_valid) check(!bus.in_ready, "ready_with_valid", bus.in_ready, 0);
      if (prev_stall)
        check({bus.out_valid, bus.out_last, bus.out_data} == hold_v, "hold",
              {bus.out_valid, bus.out_last, bus.out_data}, hold_v);
      if (lat_pending && bus.out_valid) begin
        first_lat   = cyc - acc_cyc;
        lat_pending = 1'b0;
        check(first_lat == LAT + 1, "latency", first_lat, LAT + 1);
      end
      if (just_last) begin
        check(!bus.in_ready, "ready_drop", bus.in_ready, 0);
        check(core_x == exp_x, "core_x", core_x, exp_x);
        just_last = 1'b0;
      end
      // Input acceptances.
      if (bus.in_valid && bus.in_ready) begin
        acc_n++;
        if (cur.size() < N_LANES) cur.push_back(bus.in_data);
        if (acc_n == N_LANES && !bus.in_last) err_m = 1'b1;
        if (bus.in_last) begin
          for (int i = 0; i < N_LANES; i++) exp_x[i] = (i < cur.size()) ? cur[i] : PAD;
          foreach (cur[i]) begin
            exp_d.push_back({1'b0, cur[i]} + 17'd1);
            exp_l.push_back(i == cur.size() - 1);
          end
          cur.delete();
          acc_n = 0; just_last = 1'b1; acc_cyc = cyc; lat_pending = 1'b1;
        end
      end
      // Output beats.
      prev_stall = bus.out_valid && !bus.out_ready;
      hold_v     = {bus.out_valid, bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        check(exp_d.size() != 0, "unexpected_beat", bus.out_data, 0);
        if (exp_d.size() != 0) begin
          check(bus.out_data == exp_d[0], "out_data", bus.out_data, exp_d[0]);
          check(bus.out_last == exp_l[0], "out_last", bus.out_last, exp_l[0]);
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
        got_q.push_back(int'(bus.out_data));
        if (bus.out_last) model_vc = model_vc + 16'd1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] d, input logic l);
    int k = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 50);
    check(bus.in_ready == 1'b1, "send_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v[$]);
    foreach (v[i]) send(v[i], i == v.size() - 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while ((busy || bus.out_valid) && k < 200);
    check(!busy && !bus.out_valid, "idle", {busy, bus.out_valid}, 0);
    @(posedge clk); #1;
  endtask

  function automatic bit got_eq(input int e[$]);
    if (got_q.size() != e.size()) return 1'b0;
    foreach (e[i]) if (got_q[i] != e[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [15:0] vq[$];
    int          eq[$];
    int          k;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    check(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
    check({bus.out_data, bus.out_last} == 18'd0, "rst_out_data", {bus.out_data, bus.out_last}, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(core_x == {5{PAD}}, "rst_core_x", core_x, {5{PAD}});
    @(posedge clk); #1;

    // Full vector 10..50.
    got_q.delete();
    vq = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    send_vec(vq);
    wait_idle();
    eq = '{11, 21, 31, 41, 51};
    check(got_eq(eq), "t1_beats", got_q.size(), eq.size());
    check(vec_count == 16'd1, "t1_vec_count", vec_count, 1);
    check(first_lat == 5, "t1_latency", first_lat, 5);

    // Short vector 7,9: padding and two beats.
    got_q.delete();
    vq = '{16'd7, 16'd9};
    send_vec(vq);
    @(negedge clk);
    check(busy == 1'b1, "t2_busy", busy, 1);
    check(core_x[4:2] == {3{PAD}}, "t2_pad", core_x[4:2], {3{PAD}});
    wait_idle();
    eq = '{8, 10};
    check(got_eq(eq), "t2_beats", got_q.size(), eq.size());

    // Overlong vector 1..7: truncated, err_len sticky.
    got_q.delete();
    vq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    send_vec(vq);
    wait_idle();
    eq = '{2, 3, 4, 5, 6};
    check(got_eq(eq), "t3_beats", got_q.size(), eq.size());
    check(err_len == 1'b1, "t3_err_len", err_len, 1);
    got_q.delete();
    vq = '{16'd100};
    send_vec(vq);
    wait_idle();
    eq = '{101};
    check(got_eq(eq), "t3b_beats", got_q.size(), eq.size());
    check(err_len == 1'b1, "t3b_err_sticky", err_len, 1);
    check(vec_count == 16'd4, "t3b_vec_count", vec_count, 4);

    // Backpressure on beat 2 for three cycles.
    got_q.delete();
    vq = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    send_vec(vq);
    k = 0;
    while (got_q.size() < 1 && k < 100) begin @(posedge clk); #1; k++; end
    bus.out_ready = 1'b0;
    @(negedge clk);
    check(bus.out_valid && bus.out_data == 17'd21, "t4_stall_data", bus.out_data, 21);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle();
    eq = '{11, 21, 31, 41, 51};
    check(got_eq(eq), "t4_beats", got_q.size(), eq.size());

    // Reset in the second RUN cycle abandons the vector.
    got_q.delete();
    vq = '{16'd1, 16'd2, 16'd3};
    send_vec(vq);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check(bus.out_valid == 1'b0, "t5_out_valid", bus.out_valid, 0);
    check(bus.in_ready == 1'b1, "t5_in_ready", bus.in_ready, 1);
    check(core_x == {5{PAD}}, "t5_core_x", core_x, {5{PAD}});
    check(vec_count == 16'd0, "t5_vec_count", vec_count, 0);
    check(err_len == 1'b0, "t5_err_len", err_len, 0);
    repeat (12) @(negedge clk);
    check(got_q.size() == 0, "t5_no_beats", got_q.size(), 0);
    @(posedge clk); #1;

    // vec_count wrap from FFFF.
    @(posedge clk); #2;
    force dut.vec_count = 16'hFFFF;
    model_vc = 16'hFFFF;
    @(negedge clk);
    @(posedge clk); #1;
    release dut.vec_count;
    got_q.delete();
    vq = '{16'd5};
    send_vec(vq);
    wait_idle();
    eq = '{6};
    check(got_eq(eq), "t6_beats", got_q.size(), eq.size());
    check(vec_count == 16'd0, "t6_wrap", vec_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
